mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter sharing the single-port, one-cycle-latency word memory between the processor's instruction-fetch port (port 0) and its load/store port (port 1). It sits between the core and the memory. It latches single-cycle request strobes from each port, grants the memory round-robin, and issues one access at a time. Read data and a one-cycle done pulse go back to the originating port.

## Interface
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, data word width
- `clk`  in  1  clock, all logic on rising edge
- `resetn`  in  1  reset, asynchronous, active-low
- `p0_addr`  in  ADDR_W  fetch byte address, sampled when `p0_rstrb`=1
- `p0_rstrb`  in  1  fetch read request, one-cycle pulse
- `p0_rdata`  out  DATA_W  fetch read data, held until next p0 completion
- `p0_done`  out  1  one-cycle pulse, p0 access complete
- `p1_addr`  in  ADDR_W  load/store byte address, sampled on request
- `p1_rstrb`  in  1  load request, one-cycle pulse
- `p1_wdata`  in  DATA_W  store data, sampled with `p1_wmask`
- `p1_wmask`  in  4  store byte mask; nonzero for one cycle = store request
- `p1_rdata`  out  DATA_W  load data, held until next p1 load completion
- `p1_done`  out  1  one-cycle pulse, p1 load or store complete
- `mem_addr`  out  ADDR_W  memory byte address; memory indexes word `[31:2]`
- `mem_rstrb`  out  1  memory read strobe
- `mem_wdata`  out  DATA_W  memory write data
- `mem_wmask`  out  4  memory byte write mask
- `mem_rdata`  in  DATA_W  memory read data, valid the cycle after `mem_rstrb`

## Operation
- Per port, one pending slot: `pend`, captured address, and for p1 also `is_write`, wdata and wmask.
- The slot loads on a request strobe while empty.
- A strobe while the slot is already pending is dropped; there is no queue. This is a protocol violation, and the bench flags it.
- On p1, `p1_rstrb` and nonzero `p1_wmask` in the same cycle are treated as a store. `p1_rdata` is left unchanged.
- FSM states:
  - IDLE: no access in flight. If any `pend` is set, grant one port and issue this cycle, then go to BUSY.
  - BUSY: memory data valid this cycle. Capture it (reads) into the granted port's rdata register, clear that port's `pend`, then go to IDLE.
- Issue (IDLE with a grant, combinational from registers):
  - `mem_addr` = granted captured address.
  - Read: `mem_rstrb`=1, `mem_wmask`=0.
  - Store: `mem_rstrb`=0, `mem_wmask`=captured mask, `mem_wdata`=captured data.
- Outside issue cycles: `mem_addr`, `mem_wdata`, `mem_wmask` and `mem_rstrb` are 0.
- Arbitration is round-robin on register `last`:
  - Both ports pending → grant `!last`.
  - One port pending → grant that port.
  - `last` updates to the granted port on each issue.
- A new request on a port can be captured in the same cycle that port's `pend` clears, because clear and set happen at the same edge. Set wins.

## Timing
- Uncontended request strobed in cycle N:
  - `pend`=1 in N+1.
  - Issue in N+1.
  - Memory data valid in N+2.
  - rdata registered and `done`=1 in N+3.
- Throughput: one access per 2 cycles (IDLE→BUSY→IDLE).
- A contended request waits at most one extra access (2 cycles).
- Reset values: FSM=IDLE, `last`=1 (port 0 wins the first tie), all `pend`=0, `p0_rdata`=`p1_rdata`=0, `p0_done`=`p1_done`=0, all `mem_*` outputs 0.
- Reset asserted mid-access:
  - Everything clears immediately.
  - The in-flight memory result is discarded.
  - No `done` pulse follows.
  - Pending requests are lost; requesters must re-strobe.
- `done` is never high on both ports in the same cycle.

## Structure
- Package `mem_arb_pkg`:
  - FSM state enum (IDLE, BUSY).
  - Port index constants `PORT_FETCH`=0, `PORT_LS`=1.
  - Mask width constant 4.
- Sub-module `rr_arb2`: combinational 2-way round-robin picker. Inputs: `req[1:0]`, `last`. Outputs: `gnt_valid`, `gnt_idx`.
- Everything else lives in `mem_arbiter`.

## Test plan
- Fetch only: memory word 2 = 0x00000013. Pulse `p0_rstrb` with `p0_addr`=0x8 in cycle 5 → `mem_rstrb`=1 with `mem_addr`=0x8 in cycle 6; `p0_done`=1 with `p0_rdata`=0x00000013 in cycle 8.
- Simultaneous: `p0_rstrb` (addr 0x0) and `p1_rstrb` (addr 0x40) in the same cycle after reset → port 0 issued first and port 1 issued 2 cycles later. `p0_done` and `p1_done` pulse 2 cycles apart and never overlap.
- Round-robin: both ports re-strobe immediately on every `done` for 8 accesses → grants alternate 0,1,0,1,…. Neither port waits more than 2 cycles beyond the uncontended latency.
- Store then load: `p1_wmask`=4'b1111, `p1_wdata`=0xDEADBEEF, addr 0x10; then `p1_rstrb` at 0x10 → `mem_wmask`=4'hF on issue, `p1_done` pulses, and the subsequent load returns 0xDEADBEEF. `p1_rdata` is unchanged by the store.
- Duplicate strobe: second `p0_rstrb` while p0 is pending → exactly one memory access and exactly one `p0_done`.
- Reset mid-access: drop `resetn` in the BUSY cycle → all outputs 0 asynchronously, no `done` pulse afterward, and a fresh request after release completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int unsigned PORT_FETCH = 0;
    localparam int unsigned PORT_LS    = 1;
    localparam int unsigned MASK_W     = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the port that did not win last time goes.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = (&req) ? ~last : req[1];
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a one-cycle-latency word memory between the fetch port and the
// load/store port, one access at a time, round-robin on contention.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic              p0_rstrb,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_done,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic              p1_rstrb,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [MASK_W-1:0] p1_wmask,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rstrb,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic              gnt_q, gnt_d;
    logic              p0_pend_q, p0_pend_d;
    logic [ADDR_W-1:0] p0_addr_q, p0_addr_d;
    logic              p1_pend_q, p1_pend_d;
    logic [ADDR_W-1:0] p1_addr_q, p1_addr_d;
    logic              p1_wr_q, p1_wr_d;
    logic [DATA_W-1:0] p1_wdata_q, p1_wdata_d;
    logic [MASK_W-1:0] p1_wmask_q, p1_wmask_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
    logic              p0_done_q, p0_done_d;
    logic              p1_done_q, p1_done_d;
    logic              clr0, clr1;
    logic              gnt_valid, gnt_idx;

    rr_arb2 u_rr (
        .req       ({p1_pend_q, p0_pend_q}),
        .last      (last_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Access sequencing; memory-side signals are driven only in the issue cycle.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        p0_done_d  = 1'b0;
        p1_done_d  = 1'b0;
        clr0       = 1'b0;
        clr1       = 1'b0;
        mem_addr   = '0;
        mem_rstrb  = 1'b0;
        mem_wdata  = '0;
        mem_wmask  = '0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d = BUSY;
                    last_d  = gnt_idx;
                    gnt_d   = gnt_idx;
                    if (gnt_idx == 1'(PORT_LS)) begin
                        mem_addr = p1_addr_q;
                        if (p1_wr_q) begin
                            mem_wmask = p1_wmask_q;
                            mem_wdata = p1_wdata_q;
                        end else begin
                            mem_rstrb = 1'b1;
                        end
                    end else begin
                        mem_addr  = p0_addr_q;
                        mem_rstrb = 1'b1;
                    end
                end
            end
            BUSY: begin
                state_d = IDLE;
                if (gnt_q == 1'(PORT_LS)) begin
                    clr1      = 1'b1;
                    p1_done_d = 1'b1;
                    if (!p1_wr_q) p1_rdata_d = mem_rdata;
                end else begin
                    clr0       = 1'b1;
                    p0_done_d  = 1'b1;
                    p0_rdata_d = mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending slots: a strobe loads an empty slot, or one being retired this cycle.
    always_comb begin
        p0_pend_d  = p0_pend_q & ~clr0;
        p0_addr_d  = p0_addr_q;
        p1_pend_d  = p1_pend_q & ~clr1;
        p1_addr_d  = p1_addr_q;
        p1_wr_d    = p1_wr_q;
        p1_wdata_d = p1_wdata_q;
        p1_wmask_d = p1_wmask_q;
        if (p0_rstrb && (!p0_pend_q || clr0)) begin
            p0_pend_d = 1'b1;
            p0_addr_d = p0_addr;
        end
        if ((p1_rstrb || (p1_wmask != '0)) && (!p1_pend_q || clr1)) begin
            p1_pend_d  = 1'b1;
            p1_addr_d  = p1_addr;
            p1_wr_d    = (p1_wmask != '0);
            p1_wdata_d = p1_wdata;
            p1_wmask_d = p1_wmask;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            gnt_q      <= 1'b0;
            p0_pend_q  <= 1'b0;
            p0_addr_q  <= '0;
            p1_pend_q  <= 1'b0;
            p1_addr_q  <= '0;
            p1_wr_q    <= 1'b0;
            p1_wdata_q <= '0;
            p1_wmask_q <= '0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
            p0_done_q  <= 1'b0;
            p1_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            p0_pend_q  <= p0_pend_d;
            p0_addr_q  <= p0_addr_d;
            p1_pend_q  <= p1_pend_d;
            p1_addr_q  <= p1_addr_d;
            p1_wr_q    <= p1_wr_d;
            p1_wdata_q <= p1_wdata_d;
            p1_wmask_q <= p1_wmask_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
            p0_done_q  <= p0_done_d;
            p1_done_q  <= p1_done_d;
        end
    end

    assign p0_rdata = p0_rdata_q;
    assign p1_rdata = p1_rdata_q;
    assign p0_done  = p0_done_q;
    assign p1_done  = p1_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner sequences, random traffic.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] p0_addr = '0;
    logic        p0_rstrb = 1'b0;
    logic [31:0] p0_rdata;
    logic        p0_done;
    logic [31:0] p1_addr = '0;
    logic        p1_rstrb = 1'b0;
    logic [31:0] p1_wdata = '0;
    logic [3:0]  p1_wmask = '0;
    logic [31:0] p1_rdata;
    logic        p1_done;
    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;

    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    logic        fill_req = 1'b0;
    logic [31:0] fill_seed = '0;
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];

    typedef struct {
        logic        p0_en;
        logic [31:0] p0_addr;
        logic        p1_en;
        logic [3:0]  p1_wmask;
        logic [31:0] p1_addr;
        logic [31:0] p1_wdata;
        logic [31:0] exp_p0;
        logic [31:0] exp_p1;
        int          lat0;
        int          lat1;
    } vec_t;

    vec_t vecs [9];

    mem_arbiter dut (
        .clk       (clk),
        .resetn    (resetn),
        .p0_addr   (p0_addr),
        .p0_rstrb  (p0_rstrb),
        .p0_rdata  (p0_rdata),
        .p0_done   (p0_done),
        .p1_addr   (p1_addr),
        .p1_rstrb  (p1_rstrb),
        .p1_wdata  (p1_wdata),
        .p1_wmask  (p1_wmask),
        .p1_rdata  (p1_rdata),
        .p1_done   (p1_done),
        .mem_addr  (mem_addr),
        .mem_rstrb (mem_rstrb),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fill_val(input int i, input logic [31:0] seed);
        if (seed == 32'h0) return (i == 2) ? 32'h0000_0013 : (32'hA000_0000 | 32'(i));
        return (32'(i) * 32'h9E37_79B1) ^ seed;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Word memory with one-cycle read latency; garbage when not strobed.
    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < 64; i++) mem[i] <= fill_val(i, fill_seed);
        end else begin
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        mem_rdata <= mem_rstrb ? mem[mem_addr[7:2]] : 32'hBAD0_BAD0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) if (mon_en) chk("done_overlap", 32'(p0_done & p1_done), 32'h0);

    task automatic chk_all_zero(input string tag);
        chk({tag, "_p0_rdata"}, p0_rdata, 32'h0);
        chk({tag, "_p1_rdata"}, p1_rdata, 32'h0);
        chk({tag, "_dones"}, 32'({p0_done, p1_done}), 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_ctl"}, 32'({mem_rstrb, mem_wmask}), 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        int d0, d1, n0, n1;
        d0 = 0; d1 = 0; n0 = 0; n1 = 0;
        p0_addr  = v.p0_addr;
        p0_rstrb = v.p0_en;
        p1_addr  = v.p1_addr;
        p1_wdata = v.p1_wdata;
        p1_wmask = v.p1_en ? v.p1_wmask : 4'h0;
        p1_rstrb = v.p1_en && (v.p1_wmask == 4'h0);
        for (int t = 1; t <= 8; t++) begin
            tick();
            p0_rstrb = 1'b0;
            p1_rstrb = 1'b0;
            p1_wmask = 4'h0;
            if (p0_done) begin n0++; if (d0 == 0) d0 = t; end
            if (p1_done) begin n1++; if (d1 == 0) d1 = t; end
        end
        chk($sformatf("vec%0d_p0_latency", idx), 32'(d0), 32'(v.lat0));
        chk($sformatf("vec%0d_p1_latency", idx), 32'(d1), 32'(v.lat1));
        chk($sformatf("vec%0d_p0_ndone", idx), 32'(n0), 32'(v.p0_en));
        chk($sformatf("vec%0d_p1_ndone", idx), 32'(n1), 32'(v.p1_en));
        chk($sformatf("vec%0d_p0_rdata", idx), p0_rdata, v.exp_p0);
        chk($sformatf("vec%0d_p1_rdata", idx), p1_rdata, v.exp_p1);
    endtask

    initial begin
        int n_acc, n_done, n_iss, prev_port, t0, t1;
        int o0, o1, nd;
        logic [31:0] a0, a1, wd1, hold1, expv;
        logic [3:0]  m1;
        logic        w1;

        // Scenarios from reset; latencies assume last=1 after reset.
        vecs[0] = '{1'b1, 32'h08, 1'b0, 4'h0, 32'h00, 32'h0,         32'h0000_0013, 32'h0000_0000, 3, 0};
        vecs[1] = '{1'b0, 32'h00, 1'b1, 4'h0, 32'h40, 32'h0,         32'h0000_0013, 32'hA000_0010, 0, 3};
        vecs[2] = '{1'b1, 32'h00, 1'b1, 4'h0, 32'h44, 32'h0,         32'hA000_0000, 32'hA000_0011, 3, 5};
        vecs[3] = '{1'b0, 32'h00, 1'b1, 4'h3, 32'h0C, 32'h1234_5678, 32'hA000_0000, 32'hA000_0011, 0, 3};
        vecs[4] = '{1'b1, 32'h0C, 1'b1, 4'h0, 32'h0C, 32'h0,         32'hA000_5678, 32'hA000_5678, 3, 5};
        vecs[5] = '{1'b1, 32'h08, 1'b1, 4'hC, 32'h08, 32'hCAFE_0000, 32'h0000_0013, 32'hA000_5678, 3, 5};
        vecs[6] = '{1'b1, 32'h08, 1'b0, 4'h0, 32'h00, 32'h0,         32'hCAFE_0013, 32'hA000_5678, 3, 0};
        vecs[7] = '{1'b1, 32'h40, 1'b1, 4'h0, 32'h09, 32'h0,         32'hA000_0010, 32'hCAFE_0013, 5, 3};
        vecs[8] = '{1'b1, 32'h40, 1'b1, 4'hF, 32'h40, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hCAFE_0013, 5, 3};

        fill_seed = 32'h0;
        fill_req  = 1'b1;
        tick();
        fill_req = 1'b0;
        tick();
        chk_all_zero("reset");
        resetn = 1'b1;
        tick();
        mon_en = 1'b1;

        for (int i = 0; i < 9; i++) begin
            apply_vec(i, vecs[i]);
            tick();
        end

        // Fetch-only cycle timing; word 2 now holds 0xCAFE0013.
        p0_addr = 32'h8; p0_rstrb = 1'b1;
        tick();
        p0_rstrb = 1'b0;
        chk("fetch_issue_rstrb", 32'(mem_rstrb), 32'h1);
        chk("fetch_issue_addr", mem_addr, 32'h8);
        chk("fetch_issue_wmask", 32'(mem_wmask), 32'h0);
        tick();
        chk("fetch_busy_quiet", 32'({mem_rstrb, mem_wmask}), 32'h0);
        chk("fetch_busy_no_done", 32'(p0_done), 32'h0);
        tick();
        chk("fetch_done", 32'(p0_done), 32'h1);
        chk("fetch_rdata", p0_rdata, 32'hCAFE_0013);
        tick();
        chk("fetch_done_pulse", 32'(p0_done), 32'h0);

        // Full-word store then load on port 1.
        p1_addr = 32'h10; p1_wdata = 32'hDEAD_BEEF; p1_wmask = 4'hF;
        tick();
        p1_wmask = 4'h0; p1_wdata = 32'h0;
        chk("store_issue_wmask", 32'(mem_wmask), 32'hF);
        chk("store_issue_rstrb", 32'(mem_rstrb), 32'h0);
        chk("store_issue_addr", mem_addr, 32'h10);
        chk("store_issue_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick(); tick();
        chk("store_done", 32'(p1_done), 32'h1);
        chk("store_rdata_held", p1_rdata, 32'hCAFE_0013);
        tick();
        p1_rstrb = 1'b1;
        tick();
        p1_rstrb = 1'b0;
        chk("load_issue_rstrb", 32'(mem_rstrb), 32'h1);
        tick(); tick();
        chk("load_done", 32'(p1_done), 32'h1);
        chk("load_rdata", p1_rdata, 32'hDEAD_BEEF);
        tick();

        // Second strobe while pending is dropped.
        p0_addr = 32'h0; p0_rstrb = 1'b1;
        n_acc = 0; n_done = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (t >= 1) p0_rstrb = 1'b0;
            n_acc  += int'(mem_rstrb);
            n_done += int'(p0_done);
        end
        chk("dup_accesses", 32'(n_acc), 32'h1);
        chk("dup_dones", 32'(n_done), 32'h1);
        chk("dup_rdata", p0_rdata, 32'hA000_0000);

        // Round-robin under saturation: re-strobe on every done.
        p0_addr = 32'h0; p1_addr = 32'h40;
        p0_rstrb = 1'b1; p1_rstrb = 1'b1;
        t0 = 0; t1 = 0; n_iss = 0; prev_port = -1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            p0_rstrb = 1'b0; p1_rstrb = 1'b0;
            if (mem_rstrb) begin
                if (prev_port >= 0)
                    chk("rr_alternate", 32'(int'(mem_addr == 32'h40) != prev_port), 32'h1);
                prev_port = int'(mem_addr == 32'h40);
                n_iss++;
            end
            if (p0_done) begin
                chk("rr_p0_latency", 32'((c - t0) <= 5), 32'h1);
                if (c < 22) begin p0_rstrb = 1'b1; t0 = c; end
            end
            if (p1_done) begin
                chk("rr_p1_latency", 32'((c - t1) <= 5), 32'h1);
                if (c < 22) begin p1_rstrb = 1'b1; t1 = c; end
            end
        end
        chk("rr_enough_issues", 32'(n_iss >= 8), 32'h1);

        // Reset in the BUSY cycle of a fetch.
        p0_addr = 32'h8; p0_rstrb = 1'b1;
        tick();
        p0_rstrb = 1'b0;
        chk("rma_issue", 32'(mem_rstrb), 32'h1);
        tick();
        resetn = 1'b0;
        #1;
        chk_all_zero("rma");
        tick(); tick();
        resetn = 1'b1;
        nd = 0;
        for (int t = 0; t < 6; t++) begin
            tick();
            nd += int'(p0_done) + int'(p1_done);
        end
        chk("rma_no_done", 32'(nd), 32'h0);
        p0_addr = 32'h8; p1_addr = 32'h40; p0_rstrb = 1'b1; p1_rstrb = 1'b1;
        tick();
        p0_rstrb = 1'b0; p1_rstrb = 1'b0;
        chk("rma_tie_to_p0", mem_addr, 32'h8);
        tick(); tick();
        chk("rma_p0_done", 32'(p0_done), 32'h1);
        chk("rma_p0_rdata", p0_rdata, 32'hCAFE_0013);
        tick(); tick();
        chk("rma_p1_done", 32'(p1_done), 32'h1);
        chk("rma_p1_rdata", p1_rdata, 32'hDEAD_BEEF);
        tick();

        // Random legal traffic against a transaction-level model.
        resetn = 1'b0;
        fill_seed = 32'h5A5A_1234;
        fill_req  = 1'b1;
        for (int i = 0; i < 64; i++) ref_mem[i] = fill_val(i, fill_seed);
        tick();
        fill_req = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        o0 = -1; o1 = -1; nd = 0; hold1 = 32'h0;
        a0 = '0; a1 = '0; wd1 = '0; m1 = '0; w1 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            p0_rstrb = 1'b0; p1_rstrb = 1'b0; p1_wmask = 4'h0;
            if (p0_done) begin
                if (o0 < 0) chk("rnd_p0_unexpected_done", 32'h1, 32'h0);
                else begin
                    chk("rnd_p0_latency", 32'((c - o0) >= 3 && (c - o0) <= 5), 32'h1);
                    chk("rnd_p0_rdata", p0_rdata, ref_mem[a0[7:2]]);
                    o0 = -1; nd++;
                end
            end
            if (p1_done) begin
                if (o1 < 0) chk("rnd_p1_unexpected_done", 32'h1, 32'h0);
                else begin
                    chk("rnd_p1_latency", 32'((c - o1) >= 3 && (c - o1) <= 5), 32'h1);
                    if (w1) begin
                        ref_mem[a1[7:2]] = merge(ref_mem[a1[7:2]], wd1, m1);
                        chk("rnd_p1_rdata_held", p1_rdata, hold1);
                    end else begin
                        expv  = ref_mem[a1[7:2]];
                        hold1 = expv;
                        chk("rnd_p1_rdata", p1_rdata, expv);
                    end
                    o1 = -1; nd++;
                end
            end
            if (o0 >= 0 && (c - o0) > 5) begin chk("rnd_p0_timeout", 32'h1, 32'h0); o0 = -1; end
            if (o1 >= 0 && (c - o1) > 5) begin chk("rnd_p1_timeout", 32'h1, 32'h0); o1 = -1; end
            if (c < 2990) begin
                if (o0 < 0 && $urandom_range(0, 2) == 0) begin
                    a0 = 32'($urandom_range(0, 255));
                    p0_addr = a0; p0_rstrb = 1'b1; o0 = c;
                end
                if (o1 < 0 && $urandom_range(0, 2) == 0) begin
                    a1 = 32'($urandom_range(0, 255));
                    w1 = 1'($urandom_range(0, 1));
                    p1_addr = a1; o1 = c;
                    if (w1) begin
                        m1  = 4'($urandom_range(1, 15));
                        wd1 = $urandom;
                        p1_wmask = m1; p1_wdata = wd1;
                    end else begin
                        p1_rstrb = 1'b1;
                    end
                end
            end
        end
        chk("rnd_activity", 32'(nd > 200), 32'h1);
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
